// File: rtl/hazard_unit_if.sv
// Signal bundle between the pipeline datapath and the hazard unit.
// The pipeline side uses the master modport; the hazard unit uses the slave modport.
interface hazard_unit_if;
  logic        ihit;
  logic        dhit;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  ex_writeReg;
  logic        ex_dmemREN;
  logic        mem_dmemREN;
  logic        mem_dmemWEN;
  logic        ex_branch_taken;
  logic        pc_en;
  logic        ifid_en;
  logic        idex_en;
  logic        exmem_en;
  logic        memwb_en;
  logic        ifid_flush;
  logic        idex_flush;
  logic [1:0]  state;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  modport master (
    output ihit, dhit, id_rs, id_rt, ex_writeReg, ex_dmemREN,
           mem_dmemREN, mem_dmemWEN, ex_branch_taken,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, state, stall_cnt, flush_cnt
  );

  modport slave (
    input  ihit, dhit, id_rs, id_rt, ex_writeReg, ex_dmemREN,
           mem_dmemREN, mem_dmemWEN, ex_branch_taken,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: memory-wait freeze, branch flush, load-use stall and
// fetch-miss bubble, with stall/flush performance counters.
module hazard_unit (
  input  logic         CLK,
  input  logic         RST,
  hazard_unit_if.slave bus
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    BFLUSH = 2'd2
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic        mem_wait;
  logic        load_use;
  logic        branch_flush;
  logic        pc_en;
  logic        ifid_en;
  logic        idex_en;
  logic        exmem_en;
  logic        memwb_en;
  logic        ifid_flush;
  logic        idex_flush;
  logic [1:0]  cnt_inc;
  logic [15:0] cnt_reg [2];

  assign mem_wait = (bus.mem_dmemREN | bus.mem_dmemWEN) & ~bus.dhit;
  assign load_use = bus.ex_dmemREN && (bus.ex_writeReg != 5'd0) &&
                    ((bus.ex_writeReg == bus.id_rs) || (bus.ex_writeReg == bus.id_rt));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // Outputs depend only on inputs; DWAIT/BFLUSH fall back to the RUN rules
  // once their condition clears, so the state only steers the next state.
  always_comb begin
    state_next   = RUN;
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    idex_en      = 1'b1;
    exmem_en     = 1'b1;
    memwb_en     = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    branch_flush = 1'b0;
    if (RST) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      exmem_en   = 1'b0;
      memwb_en   = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (mem_wait) begin
      // Freezing EX also defers any taken branch until the dhit cycle.
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      exmem_en   = 1'b0;
      memwb_en   = 1'b0;
      state_next = DWAIT;
    end else if (bus.ex_branch_taken) begin
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      branch_flush = 1'b1;
      state_next   = BFLUSH;
    end else if (load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end else if (!bus.ihit) begin
      pc_en      = 1'b0;
      ifid_flush = 1'b1;
    end
  end

  assign cnt_inc[0] = ~pc_en & ~RST;
  assign cnt_inc[1] = branch_flush;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      always_ff @(posedge CLK) begin
        if (RST) begin
          cnt_reg[gi] <= 16'd0;
        end else if (cnt_inc[gi] && (cnt_reg[gi] != 16'hFFFF)) begin
          cnt_reg[gi] <= cnt_reg[gi] + 16'd1;
        end
      end
    end
  endgenerate

  assign bus.pc_en      = pc_en;
  assign bus.ifid_en    = ifid_en;
  assign bus.idex_en    = idex_en;
  assign bus.exmem_en   = exmem_en;
  assign bus.memwb_en   = memwb_en;
  assign bus.ifid_flush = ifid_flush;
  assign bus.idex_flush = idex_flush;
  assign bus.state      = state_reg;
  assign bus.stall_cnt  = cnt_reg[0];
  assign bus.flush_cnt  = cnt_reg[1];

endmodule

// File: tb/tb_hazard_unit.sv
// Directed vector bench for hazard_unit: table of single-cycle vectors plus
// hand-written wait, deferred-branch, reset-abandon and saturation sequences.
module tb_hazard_unit;

  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_DWAIT  = 2'd1;
  localparam logic [1:0] S_BFLUSH = 2'd2;

  // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush}
  localparam logic [6:0] O_NONE  = 7'b11111_00;
  localparam logic [6:0] O_LU    = 7'b00111_01;
  localparam logic [6:0] O_MISS  = 7'b01111_10;
  localparam logic [6:0] O_BR    = 7'b11111_11;
  localparam logic [6:0] O_WAIT  = 7'b00000_00;
  localparam logic [6:0] O_RST   = 7'b00000_11;

  typedef struct {
    string      name;
    logic       ihit;
    logic       dhit;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] wr;
    logic       exren;
    logic       mren;
    logic       mwen;
    logic       br;
    logic [6:0] exp_out;
    logic [1:0] exp_state;
    int         stall_inc;
    int         flush_inc;
  } vec_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;
  int   exp_stall;
  int   exp_flush;
  vec_t vecs [18];

  hazard_unit_if hif ();

  hazard_unit dut (
    .CLK (clk),
    .RST (rst),
    .bus (hif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkv(string name, logic ihit, logic dhit, logic [4:0] rs,
                               logic [4:0] rt, logic [4:0] wr, logic exren, logic mren,
                               logic mwen, logic br, logic [6:0] exp_out,
                               logic [1:0] exp_state, int stall_inc, int flush_inc);
    vec_t v;
    v.name = name; v.ihit = ihit; v.dhit = dhit; v.rs = rs; v.rt = rt; v.wr = wr;
    v.exren = exren; v.mren = mren; v.mwen = mwen; v.br = br;
    v.exp_out = exp_out; v.exp_state = exp_state;
    v.stall_inc = stall_inc; v.flush_inc = flush_inc;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(logic ihit, logic dhit, logic [4:0] rs, logic [4:0] rt,
                        logic [4:0] wr, logic exren, logic mren, logic mwen, logic br);
    hif.ihit = ihit; hif.dhit = dhit; hif.id_rs = rs; hif.id_rt = rt;
    hif.ex_writeReg = wr; hif.ex_dmemREN = exren; hif.mem_dmemREN = mren;
    hif.mem_dmemWEN = mwen; hif.ex_branch_taken = br;
  endtask

  function automatic logic [6:0] outs();
    return {hif.pc_en, hif.ifid_en, hif.idex_en, hif.exmem_en, hif.memwb_en,
            hif.ifid_flush, hif.idex_flush};
  endfunction

  function automatic int sat_add(int cnt, int inc);
    return (cnt + inc > 65535) ? 65535 : cnt + inc;
  endfunction

  // One cycle: inputs already driven just after a rising edge. Outputs are
  // sampled at the falling edge, registered state/counters just after the next rise.
  task automatic cyc(string name, logic [6:0] exp_out, logic [1:0] exp_state);
    @(negedge clk);
    chk({name, ".outs"}, 32'(outs()), 32'(exp_out));
    @(posedge clk);
    #1;
    chk({name, ".state"}, 32'(hif.state), 32'(exp_state));
    chk({name, ".stall_cnt"}, 32'(hif.stall_cnt), 32'(exp_stall));
    chk({name, ".flush_cnt"}, 32'(hif.flush_cnt), 32'(exp_flush));
    $display("cycle %-14s outs=%b state=%0d stall=%0d flush=%0d",
             name, outs(), hif.state, hif.stall_cnt, hif.flush_cnt);
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    exp_stall = 0;
    exp_flush = 0;

    //             name          ih dh rs    rt    wr    ld mr mw br  outs    next      st fl
    vecs[0]  = mkv("idle",        1, 0, 5'd1, 5'd2, 5'd3, 0, 0, 0, 0, O_NONE, S_RUN,    0, 0);
    vecs[1]  = mkv("lu_rs",       1, 0, 5'd8, 5'd2, 5'd8, 1, 0, 0, 0, O_LU,   S_RUN,    1, 0);
    vecs[2]  = mkv("lu_bubble",   1, 0, 5'd8, 5'd2, 5'd0, 0, 0, 0, 0, O_NONE, S_RUN,    0, 0);
    vecs[3]  = mkv("lu_zero",     1, 0, 5'd0, 5'd2, 5'd0, 1, 0, 0, 0, O_NONE, S_RUN,    0, 0);
    vecs[4]  = mkv("lu_rt",       1, 0, 5'd3, 5'd5, 5'd5, 1, 0, 0, 0, O_LU,   S_RUN,    1, 0);
    vecs[5]  = mkv("ld_nomatch",  1, 0, 5'd3, 5'd4, 5'd5, 1, 0, 0, 0, O_NONE, S_RUN,    0, 0);
    vecs[6]  = mkv("alu_match",   1, 0, 5'd8, 5'd2, 5'd8, 0, 0, 0, 0, O_NONE, S_RUN,    0, 0);
    vecs[7]  = mkv("fetch_miss",  0, 0, 5'd1, 5'd2, 5'd3, 0, 0, 0, 0, O_MISS, S_RUN,    1, 0);
    vecs[8]  = mkv("branch",      1, 0, 5'd1, 5'd2, 5'd3, 0, 0, 0, 1, O_BR,   S_BFLUSH, 0, 1);
    vecs[9]  = mkv("bflush_miss", 0, 0, 5'd1, 5'd2, 5'd3, 0, 0, 0, 0, O_MISS, S_RUN,    1, 0);
    vecs[10] = mkv("br_lu",       1, 0, 5'd8, 5'd2, 5'd8, 1, 0, 0, 1, O_BR,   S_BFLUSH, 0, 1);
    vecs[11] = mkv("br_miss",     0, 0, 5'd1, 5'd2, 5'd3, 0, 0, 0, 1, O_BR,   S_BFLUSH, 0, 1);
    vecs[12] = mkv("br_again",    1, 0, 5'd1, 5'd2, 5'd3, 0, 0, 0, 1, O_BR,   S_BFLUSH, 0, 1);
    vecs[13] = mkv("mem_hit",     1, 1, 5'd1, 5'd2, 5'd3, 0, 1, 0, 0, O_NONE, S_RUN,    0, 0);
    vecs[14] = mkv("mem_wait",    1, 0, 5'd1, 5'd2, 5'd3, 0, 0, 1, 0, O_WAIT, S_DWAIT,  1, 0);
    vecs[15] = mkv("wait_lu_miss",0, 0, 5'd8, 5'd2, 5'd8, 1, 1, 0, 0, O_WAIT, S_DWAIT,  1, 0);
    vecs[16] = mkv("dhit_lu",     1, 1, 5'd8, 5'd2, 5'd8, 1, 1, 0, 0, O_LU,   S_RUN,    1, 0);
    vecs[17] = mkv("idle2",       1, 0, 5'd1, 5'd2, 5'd3, 0, 0, 0, 0, O_NONE, S_RUN,    0, 0);

    // Reset: enables low, flushes high, state and counters cleared.
    rst = 1'b1;
    set_in(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    cyc("reset", O_RST, S_RUN);
    rst = 1'b0;

    foreach (vecs[i]) begin
      set_in(vecs[i].ihit, vecs[i].dhit, vecs[i].rs, vecs[i].rt, vecs[i].wr,
             vecs[i].exren, vecs[i].mren, vecs[i].mwen, vecs[i].br);
      exp_stall = sat_add(exp_stall, vecs[i].stall_inc);
      exp_flush = sat_add(exp_flush, vecs[i].flush_inc);
      cyc(vecs[i].name, vecs[i].exp_out, vecs[i].exp_state);
    end

    // Data wait: three miss cycles then the hit.
    for (int k = 0; k < 3; k++) begin
      set_in(1, 0, 5'd1, 5'd2, 5'd3, 0, 1, 0, 0);
      exp_stall = sat_add(exp_stall, 1);
      cyc("dwait", O_WAIT, S_DWAIT);
    end
    set_in(1, 1, 5'd1, 5'd2, 5'd3, 0, 1, 0, 0);
    cyc("dwait_hit", O_NONE, S_RUN);

    // Branch during a store wait is deferred to the dhit cycle.
    for (int k = 0; k < 2; k++) begin
      set_in(1, 0, 5'd1, 5'd2, 5'd3, 0, 0, 1, 1);
      exp_stall = sat_add(exp_stall, 1);
      cyc("br_wait", O_WAIT, S_DWAIT);
    end
    set_in(1, 1, 5'd1, 5'd2, 5'd3, 0, 0, 1, 1);
    exp_flush = sat_add(exp_flush, 1);
    cyc("br_wait_hit", O_BR, S_BFLUSH);
    set_in(1, 0, 5'd1, 5'd2, 5'd3, 0, 0, 0, 0);
    cyc("br_wait_after", O_NONE, S_RUN);

    // Reset in the middle of DWAIT.
    set_in(1, 0, 5'd1, 5'd2, 5'd3, 0, 1, 0, 0);
    exp_stall = sat_add(exp_stall, 1);
    cyc("pre_rst_wait", O_WAIT, S_DWAIT);
    rst = 1'b1;
    set_in(1, 0, 5'd1, 5'd2, 5'd3, 0, 0, 0, 0);
    exp_stall = 0;
    exp_flush = 0;
    cyc("rst_in_dwait", O_RST, S_RUN);
    rst = 1'b0;
    cyc("post_rst_dw", O_NONE, S_RUN);

    // Reset in the middle of BFLUSH.
    set_in(1, 0, 5'd1, 5'd2, 5'd3, 0, 0, 0, 1);
    exp_flush = sat_add(exp_flush, 1);
    cyc("pre_rst_br", O_BR, S_BFLUSH);
    rst = 1'b1;
    set_in(1, 0, 5'd1, 5'd2, 5'd3, 0, 0, 0, 0);
    exp_stall = 0;
    exp_flush = 0;
    cyc("rst_in_bflush", O_RST, S_RUN);
    rst = 1'b0;
    cyc("post_rst_bf", O_NONE, S_RUN);

    // Saturation: 65535 fetch-miss cycles, then one more.
    set_in(0, 0, 5'd1, 5'd2, 5'd3, 0, 0, 0, 0);
    repeat (65535) @(posedge clk);
    #1;
    exp_stall = 65535;
    chk("sat_preload", 32'(hif.stall_cnt), 32'hFFFF);
    $display("cycle %-14s stall=%0d", "sat_preload", hif.stall_cnt);
    exp_stall = sat_add(exp_stall, 1);
    cyc("sat_hold", O_MISS, S_RUN);
    set_in(1, 0, 5'd1, 5'd2, 5'd3, 0, 0, 0, 1);
    exp_flush = sat_add(exp_flush, 1);
    cyc("sat_branch", O_BR, S_BFLUSH);
    rst = 1'b1;
    set_in(1, 0, 5'd1, 5'd2, 5'd3, 0, 0, 0, 0);
    exp_stall = 0;
    exp_flush = 0;
    cyc("sat_reset", O_RST, S_RUN);
    rst = 1'b0;
    cyc("sat_after", O_NONE, S_RUN);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
